// File: rtl/cover_flood_if.sv
// Command/result channel between the PLAY logic (master) and the cover/flood engine (slave).
interface cover_flood_if #(
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [X_BITS-1:0] cmd_x;
  logic [Y_BITS-1:0] cmd_y;
  logic              opened_cell;
  logic              mine_hit;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y,
    input  cmd_ready, opened_cell, mine_hit, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y,
    output cmd_ready, opened_cell, mine_hit, busy
  );
endinterface

// File: rtl/cover_flood_engine.sv
// Owns per-cell cover state; executes flag toggles and cell opens, flood-filling zero regions
// with an explicit coordinate stack. Cells are marked opened when pushed, so each is pushed once.
module cover_flood_engine #(
  parameter int X_SIZE = 16,
  parameter int Y_SIZE = 16,
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
) (
  input  logic              board_clk,
  input  logic              glob_reset,
  cover_flood_if.slave      cf,
  output logic [X_BITS-1:0] brd_x,
  output logic [Y_BITS-1:0] brd_y,
  input  logic [4:0]        brd_val,
  input  logic [X_BITS-1:0] rd_x,
  input  logic [Y_BITS-1:0] rd_y,
  output logic [1:0]        rd_cover
);

  localparam int CELLS    = X_SIZE * Y_SIZE;
  localparam int IDX_BITS = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int XW       = X_BITS + 1;
  localparam int YW       = Y_BITS + 1;
  localparam int CW       = X_BITS + Y_BITS;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ROOT = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] NBR  = 3'd4;
  localparam logic [2:0] POP  = 3'd5;

  localparam logic [1:0] COV_COVERED = 2'b00;
  localparam logic [1:0] COV_OPENED  = 2'b01;
  localparam logic [1:0] COV_FLAGGED = 2'b10;

  localparam logic [4:0] VAL_MINE = 5'b11111;
  localparam logic [4:0] VAL_ZERO = 5'b00000;

  localparam logic [XW-1:0]       X_LIM    = XW'(X_SIZE);
  localparam logic [YW-1:0]       Y_LIM    = YW'(Y_SIZE);
  localparam logic [XW-1:0]       X_ONE    = XW'(1);
  localparam logic [YW-1:0]       Y_ONE    = YW'(1);
  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);
  localparam logic [IDX_BITS-1:0] IDX_ZERO = IDX_BITS'(0);
  localparam logic [2:0]          NBR_LAST = 3'd7;

  function automatic logic [IDX_BITS-1:0] cell_idx(input logic [X_BITS-1:0] x,
                                                   input logic [Y_BITS-1:0] y);
    return IDX_BITS'(y) * IDX_BITS'(X_SIZE) + IDX_BITS'(x);
  endfunction

  logic [1:0]          cover_r [CELLS];
  logic [CW-1:0]       stack_r [CELLS];
  logic [IDX_BITS-1:0] sp_r;

  logic [2:0]          state_r;
  logic                ready_r;
  logic                opened_r;
  logic                mine_r;
  logic                op_r;
  logic                flood_r;
  logic [X_BITS-1:0]   tx_r;
  logic [Y_BITS-1:0]   ty_r;
  logic [X_BITS-1:0]   cx_r;
  logic [Y_BITS-1:0]   cy_r;
  logic [2:0]          nbr_idx_r;
  logic [X_BITS-1:0]   brd_x_r;
  logic [Y_BITS-1:0]   brd_y_r;

  logic [XW-1:0]       nx_s;
  logic [YW-1:0]       ny_s;
  logic                nbr_in_s;
  logic [IDX_BITS-1:0] eng_idx_s;
  logic [1:0]          eng_cover_s;
  logic                cov_we_s;
  logic [1:0]          cov_wdata_s;
  logic                push_s;
  logic [CW-1:0]       top_s;

  assign cf.cmd_ready   = ready_r;
  assign cf.busy        = ~ready_r;
  assign cf.opened_cell = opened_r;
  assign cf.mine_hit    = mine_r;
  assign brd_x          = brd_x_r;
  assign brd_y          = brd_y_r;
  assign rd_cover       = cover_r[cell_idx(rd_x, rd_y)];
  assign top_s          = stack_r[sp_r - IDX_ONE];

  // Neighbour coordinate generation; one extra bit so x-1 at 0 and x+1 at the edge fall out of range.
  always_comb begin
    case (nbr_idx_r)
      3'd0, 3'd3, 3'd5: nx_s = {1'b0, cx_r} - X_ONE;
      3'd1, 3'd6:       nx_s = {1'b0, cx_r};
      default:          nx_s = {1'b0, cx_r} + X_ONE;
    endcase
    case (nbr_idx_r)
      3'd0, 3'd1, 3'd2: ny_s = {1'b0, cy_r} - Y_ONE;
      3'd3, 3'd4:       ny_s = {1'b0, cy_r};
      default:          ny_s = {1'b0, cy_r} + Y_ONE;
    endcase
    nbr_in_s = (nx_s < X_LIM) && (ny_s < Y_LIM);
  end

  // Engine read port and the single cover write port / stack push decision.
  always_comb begin
    if (state_r == NBR) begin
      eng_idx_s = cell_idx(nx_s[X_BITS-1:0], ny_s[Y_BITS-1:0]);
    end else begin
      eng_idx_s = cell_idx(tx_r, ty_r);
    end
    eng_cover_s = cover_r[eng_idx_s];
    cov_we_s    = 1'b0;
    cov_wdata_s = COV_COVERED;
    push_s      = 1'b0;
    case (state_r)
      ROOT: begin
        if (op_r) begin
          if (eng_cover_s == COV_COVERED) begin
            cov_we_s    = 1'b1;
            cov_wdata_s = COV_FLAGGED;
          end else if (eng_cover_s == COV_FLAGGED) begin
            cov_we_s    = 1'b1;
            cov_wdata_s = COV_COVERED;
          end else begin
            cov_we_s    = 1'b0;
          end
        end else if (eng_cover_s == COV_COVERED) begin
          cov_we_s    = 1'b1;
          cov_wdata_s = COV_OPENED;
        end else begin
          cov_we_s    = 1'b0;
        end
      end
      NBR: begin
        if (nbr_in_s && (eng_cover_s == COV_COVERED)) begin
          cov_we_s    = 1'b1;
          cov_wdata_s = COV_OPENED;
          push_s      = 1'b1;
        end else begin
          cov_we_s    = 1'b0;
        end
      end
      default: begin
        cov_we_s = 1'b0;
      end
    endcase
  end

  // Control FSM, command latch, result pulses, stack pointer and cover array.
  always_ff @(posedge board_clk) begin
    if (glob_reset) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      opened_r  <= 1'b0;
      mine_r    <= 1'b0;
      op_r      <= 1'b0;
      flood_r   <= 1'b0;
      tx_r      <= {X_BITS{1'b0}};
      ty_r      <= {Y_BITS{1'b0}};
      cx_r      <= {X_BITS{1'b0}};
      cy_r      <= {Y_BITS{1'b0}};
      nbr_idx_r <= 3'd0;
      brd_x_r   <= {X_BITS{1'b0}};
      brd_y_r   <= {Y_BITS{1'b0}};
      sp_r      <= IDX_ZERO;
      for (int i = 0; i < CELLS; i++) begin
        cover_r[i] <= COV_COVERED;
      end
    end else begin
      opened_r <= cov_we_s && (cov_wdata_s == COV_OPENED);
      mine_r   <= 1'b0;
      if (cov_we_s) begin
        cover_r[eng_idx_s] <= cov_wdata_s;
      end
      case (state_r)
        IDLE: begin
          if (cf.cmd_valid) begin
            op_r    <= cf.cmd_op;
            tx_r    <= cf.cmd_x;
            ty_r    <= cf.cmd_y;
            brd_x_r <= cf.cmd_x;
            brd_y_r <= cf.cmd_y;
            flood_r <= 1'b0;
            ready_r <= 1'b0;
            state_r <= ROOT;
          end
        end
        ROOT: begin
          if (op_r || (eng_cover_s != COV_COVERED)) begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= WAIT;
          end
        end
        RD: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (brd_val == VAL_ZERO) begin
            if (!flood_r) begin
              cx_r <= tx_r;
              cy_r <= ty_r;
            end
            nbr_idx_r <= 3'd0;
            state_r   <= NBR;
          end else if (flood_r) begin
            state_r <= POP;
          end else begin
            mine_r  <= (brd_val == VAL_MINE);
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        NBR: begin
          nbr_idx_r <= nbr_idx_r + 3'd1;
          if (push_s) begin
            sp_r <= sp_r + IDX_ONE;
          end
          if (nbr_idx_r == NBR_LAST) begin
            state_r <= POP;
          end
        end
        POP: begin
          if (sp_r == IDX_ZERO) begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            sp_r    <= sp_r - IDX_ONE;
            cx_r    <= top_s[X_BITS-1:0];
            cy_r    <= top_s[CW-1:X_BITS];
            brd_x_r <= top_s[X_BITS-1:0];
            brd_y_r <= top_s[CW-1:X_BITS];
            flood_r <= 1'b1;
            state_r <= RD;
          end
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Stack storage; emptiness is tracked by sp_r alone, so the entries need no reset.
  always_ff @(posedge board_clk) begin
    if (push_s) begin
      stack_r[sp_r] <= {ny_s[Y_BITS-1:0], nx_s[X_BITS-1:0]};
    end
  end

endmodule

// File: tb/tb_cover_flood_engine.sv
// Randomised and directed bench for cover_flood_engine against a BFS reference model of the board.
module tb_cover_flood_engine;
  localparam int N   = 256;
  localparam int LIM = 5000;

  logic       board_clk = 1'b0;
  logic       glob_reset;
  logic [3:0] brd_x, brd_y, rd_x, rd_y;
  logic [4:0] brd_val;
  logic [1:0] rd_cover;

  int board_v [N];
  int cov_m   [N];
  int n_checks = 0;
  int n_errors = 0;

  cover_flood_if #(.X_BITS(4), .Y_BITS(4)) cf ();

  cover_flood_engine dut (
    .board_clk (board_clk),
    .glob_reset(glob_reset),
    .cf        (cf),
    .brd_x     (brd_x),
    .brd_y     (brd_y),
    .brd_val   (brd_val),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_cover  (rd_cover)
  );

  always #5 board_clk = ~board_clk;

  always @(posedge board_clk) brd_val <= 5'(board_v[int'(brd_y) * 16 + int'(brd_x)]);

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic read_cover(input int x, input int y, output int v);
    rd_x = 4'(x);
    rd_y = 4'(y);
    #1;
    v = int'(rd_cover);
  endtask

  task automatic board_mismatches(output int n);
    int v;
    n = 0;
    for (int i = 0; i < N; i++) begin
      read_cover(i % 16, i / 16, v);
      if (v != cov_m[i]) n++;
    end
  endtask

  task automatic fill_counts();
    for (int i = 0; i < N; i++) begin
      if (board_v[i] != 31) begin
        board_v[i] = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int nx = i % 16 + dx;
            int ny = i / 16 + dy;
            if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && board_v[ny * 16 + nx] == 31)
              board_v[i]++;
          end
      end
    end
  endtask

  // Reference semantics: flag toggles; open reveals the cell and, for zeros, everything reachable.
  task automatic model_cmd(input int op, input int x, input int y, output int n_open, output int n_mine);
    int idx;
    int q[$];
    n_open = 0;
    n_mine = 0;
    idx = y * 16 + x;
    if (op == 1) begin
      if (cov_m[idx] == 0) cov_m[idx] = 2;
      else if (cov_m[idx] == 2) cov_m[idx] = 0;
    end else if (cov_m[idx] == 0) begin
      cov_m[idx] = 1;
      n_open = 1;
      if (board_v[idx] == 31) n_mine = 1;
      else if (board_v[idx] == 0) q.push_back(idx);
      while (q.size() > 0) begin
        int c = q.pop_front();
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int nx = c % 16 + dx;
            int ny = c / 16 + dy;
            if ((dx != 0 || dy != 0) && nx >= 0 && nx < 16 && ny >= 0 && ny < 16
                && cov_m[ny * 16 + nx] == 0) begin
              cov_m[ny * 16 + nx] = 1;
              n_open++;
              if (board_v[ny * 16 + nx] == 0) q.push_back(ny * 16 + nx);
            end
          end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge board_clk);
    glob_reset = 1'b1;
    @(negedge board_clk);
    glob_reset = 1'b0;
    for (int i = 0; i < N; i++) cov_m[i] = 0;
  endtask

  task automatic run_and_check(input int op, input int x, input int y, input string tag,
                               output int lowc, output int opens, output int mines);
    int lat, e_open, e_mine, mm;
    @(negedge board_clk);
    check_eq({tag, " ready_before"}, int'(cf.cmd_ready), 1);
    cf.cmd_valid = 1'b1;
    cf.cmd_op    = op[0];
    cf.cmd_x     = 4'(x);
    cf.cmd_y     = 4'(y);
    @(negedge board_clk);
    cf.cmd_valid = 1'b0;
    check_eq({tag, " brd_addr"}, int'({brd_y, brd_x}), y * 16 + x);
    check_eq({tag, " busy"}, int'(cf.busy), 1);
    opens = 0;
    mines = 0;
    lat   = 0;
    while (!cf.cmd_ready && lat < LIM) begin
      opens += int'(cf.opened_cell);
      mines += int'(cf.mine_hit);
      @(negedge board_clk);
      lat++;
    end
    check_eq({tag, " completes"}, int'(lat < LIM), 1);
    for (int k = 0; k < 3; k++) begin
      opens += int'(cf.opened_cell);
      mines += int'(cf.mine_hit);
      @(negedge board_clk);
    end
    lowc = lat;
    model_cmd(op, x, y, e_open, e_mine);
    check_eq({tag, " opened_pulses"}, opens, e_open);
    check_eq({tag, " mine_pulses"}, mines, e_mine);
    board_mismatches(mm);
    check_eq({tag, " cover_mismatch_cells"}, mm, 0);
  endtask

  initial begin
    int lowc, opens, mines, v, cnt, mm;
    glob_reset   = 1'b1;
    cf.cmd_valid = 1'b0;
    cf.cmd_op    = 1'b0;
    cf.cmd_x     = 4'd0;
    cf.cmd_y     = 4'd0;
    rd_x         = 4'd0;
    rd_y         = 4'd0;
    for (int i = 0; i < N; i++) board_v[i] = 0;
    repeat (3) @(negedge board_clk);
    glob_reset = 1'b0;
    for (int i = 0; i < N; i++) cov_m[i] = 0;
    check_eq("reset cmd_ready", int'(cf.cmd_ready), 1);
    check_eq("reset busy", int'(cf.busy), 0);
    check_eq("reset opened_cell", int'(cf.opened_cell), 0);
    check_eq("reset mine_hit", int'(cf.mine_hit), 0);
    check_eq("reset brd_addr", int'({brd_y, brd_x}), 0);
    board_mismatches(mm);
    check_eq("reset cover cells", mm, 0);

    // Flag toggle twice.
    run_and_check(1, 3, 4, "flag1", lowc, opens, mines);
    read_cover(3, 4, v);
    check_eq("flag1 cover", v, 2);
    check_eq("flag1 ready_low", lowc, 1);
    check_eq("flag1 no_open", opens, 0);
    run_and_check(1, 3, 4, "flag2", lowc, opens, mines);
    read_cover(3, 4, v);
    check_eq("flag2 cover", v, 0);
    check_eq("flag2 ready_low", lowc, 1);

    // Single non-zero open and re-open.
    for (int i = 0; i < N; i++) board_v[i] = 1;
    board_v[5 * 16 + 5] = 2;
    run_and_check(0, 5, 5, "open55", lowc, opens, mines);
    check_eq("open55 pulses", opens, 1);
    read_cover(5, 5, v);
    check_eq("open55 cover", v, 1);
    run_and_check(0, 5, 5, "reopen55", lowc, opens, mines);
    check_eq("reopen55 pulses", opens, 0);

    // Mine at the corner.
    board_v[0] = 31;
    run_and_check(0, 0, 0, "mine00", lowc, opens, mines);
    check_eq("mine00 opened", opens, 1);
    check_eq("mine00 hit", mines, 1);
    check_eq("mine00 ready_within4", int'(lowc <= 4), 1);

    // Full flood around a corner mine.
    do_reset();
    for (int i = 0; i < N; i++) board_v[i] = 0;
    board_v[255] = 31;
    fill_counts();
    run_and_check(0, 0, 0, "flood_mine", lowc, opens, mines);
    check_eq("flood_mine count", opens, 255);
    check_eq("flood_mine no_hit", mines, 0);
    read_cover(15, 15, v);
    check_eq("flood_mine corner covered", v, 0);

    // Flag blocks only itself.
    do_reset();
    for (int i = 0; i < N; i++) board_v[i] = 0;
    run_and_check(1, 1, 0, "flag10", lowc, opens, mines);
    run_and_check(0, 0, 0, "flood_flag", lowc, opens, mines);
    check_eq("flood_flag count", opens, 255);
    read_cover(1, 0, v);
    check_eq("flood_flag flag kept", v, 2);

    // Reset mid-flood.
    do_reset();
    @(negedge board_clk);
    cf.cmd_valid = 1'b1;
    cf.cmd_op    = 1'b0;
    cf.cmd_x     = 4'd7;
    cf.cmd_y     = 4'd9;
    @(negedge board_clk);
    cf.cmd_valid = 1'b0;
    cnt = 0;
    repeat (40) begin
      cnt += int'(cf.opened_cell);
      @(negedge board_clk);
    end
    check_eq("midflood started", int'(cnt > 1), 1);
    glob_reset = 1'b1;
    @(negedge board_clk);
    check_eq("midflood ready", int'(cf.cmd_ready), 1);
    check_eq("midflood opened", int'(cf.opened_cell), 0);
    for (int i = 0; i < N; i++) cov_m[i] = 0;
    board_mismatches(mm);
    check_eq("midflood cover cleared", mm, 0);
    @(negedge board_clk);
    glob_reset = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge board_clk);
      cnt += int'(cf.opened_cell) + int'(!cf.cmd_ready);
    end
    check_eq("midflood quiet after", cnt, 0);

    // Random boards and commands.
    for (int r = 0; r < 6; r++) begin
      int dens;
      do_reset();
      dens = (r == 0) ? 0 : int'($urandom_range(3, 22));
      for (int i = 0; i < N; i++) board_v[i] = (int'($urandom_range(0, 99)) < dens) ? 31 : 0;
      fill_counts();
      for (int c = 0; c < 15; c++) begin
        int op = (int'($urandom_range(0, 99)) < 25) ? 1 : 0;
        run_and_check(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      $sformatf("rnd%0d_%0d", r, c), lowc, opens, mines);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
